operand_tf_lane_seq: RTL
========================

OPERAND_TF_LANE_SEQ -- requirements
Module: operand_tf_lane_seq

Interface
REQ-001 Parameter CNT_W, default 8: width of the per-tile pair counter.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream has an element pair plus micro scale on the lane data inputs.
REQ-005 in_ready  output  1  sequencer accepts a pair this cycle.
REQ-006 in_last  input  1  pair is the final pair of the tile; sampled on accept.
REQ-007 cfg_odd_en  input  1  1 = odd element valid, 0 = even-only pair; sampled on accept.
REQ-008 load_input  output  1  lane input-buffer load strobe.
REQ-009 iter_sel  output  1  lane mux/demux select: 0 = even, 1 = odd.
REQ-010 we_result  output  1  lane result-register write enable.
REQ-011 out_valid  output  1  lane res_0/res_1 hold a complete result pair.
REQ-012 out_ready  input  1  downstream consumes the result pair.
REQ-013 out_last  output  1  result pair is the last of the tile; valid while out_valid=1.
REQ-014 pair_cnt  output  CNT_W  number of pairs delivered in the current tile.
REQ-015 tile_done  output  1  one-cycle pulse after the last pair of a tile is delivered.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, EVEN, ODD, DONE.
REQ-018 in_ready SHALL equal (state==IDLE) | (state==DONE & out_ready).
REQ-019 Accept = in_valid & in_ready; load_input SHALL equal accept, combinationally, same cycle.
REQ-020 On accept, cfg_odd_en and in_last SHALL be latched into odd_q and last_q; the next state SHALL be EVEN.
REQ-021 In EVEN: iter_sel=0, we_result=1. Next state is ODD if odd_q=1, else DONE.
REQ-022 In ODD: iter_sel=1, we_result=1. Next state is DONE.
REQ-023 In IDLE and DONE: we_result=0, iter_sel=0.
REQ-024 In DONE: out_valid=1, out_last=last_q. The state SHALL hold until out_ready=1. Then next state = EVEN if in_valid=1 (back-to-back accept), else IDLE.
REQ-025 out_valid and out_last SHALL be 0 in all states other than DONE.
REQ-026 Latency: accept at cycle T gives out_valid at T+3 with odd_q=1, or at T+2 with odd_q=0. Zero-bubble throughput is one pair per 3 cycles (2 cycles even-only).
REQ-027 In DONE, in_valid=1 with out_ready=0 SHALL NOT be accepted.
REQ-028 Outputs SHALL be independent of in_valid/cfg inputs except in_ready and load_input.
REQ-029 Delivery = out_valid & out_ready. On a delivery with out_last=0, pair_cnt SHALL increment by 1 and wrap modulo 2^CNT_W.
REQ-030 On a delivery with out_last=1, pair_cnt SHALL clear to 0 and tile_done SHALL pulse high for exactly the next cycle.
REQ-031 busy SHALL equal (state != IDLE).

Reset
REQ-032 While rst_n=0: state=IDLE, odd_q=0, last_q=0, pair_cnt=0, tile_done=0. in_ready and load_input SHALL be forced to 0. All other outputs SHALL be 0.
REQ-033 Reset asserted mid-operation (EVEN, ODD or DONE) SHALL abort the pair with no further we_result. Partial lane results SHALL be discarded.
REQ-034 After rst_n deasserts, in_ready SHALL be 1 on the first cycle.

Verification
REQ-035 Single pair, cfg_odd_en=1, in_last=0, out_ready=1, accept at cycle 0 -> we_result at cycles 1–2 with iter_sel 0 then 1; out_valid at cycle 3; pair_cnt goes 0->1.
REQ-036 Even-only pair, cfg_odd_en=0 -> exactly one we_result with iter_sel=0; out_valid at cycle 2; iter_sel never 1.
REQ-037 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid held high, in_ready=0, no load_input. Then out_ready=1 -> load_input and delivery occur in the same cycle, next state EVEN.
REQ-038 Tile of 4 pairs, last on the 4th, continuous traffic -> pair_cnt 0,1,2,3,0; one tile_done pulse in the cycle after the 4th delivery; deliveries 3 cycles apart.
REQ-039 Counter wrap, CNT_W=2: 5 non-last deliveries -> pair_cnt sequence 1,2,3,0,1.
REQ-040 rst_n pulled low during ODD -> all outputs 0 immediately. After release: state IDLE, in_ready=1, pair_cnt=0, no out_valid for the aborted pair.

Source files
------------

// File: rtl/operand_tf_lane_seq.sv
// Operand lane sequencer: accepts an element pair, steps the lane through its even
// (and optionally odd) pass, then holds the result pair until downstream takes it.
module operand_tf_lane_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic             cfg_odd_en,
    output logic             load_input,
    output logic             iter_sel,
    output logic             we_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] pair_cnt,
    output logic             tile_done,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both 1;
    // valid never waits on ready, and a held out_valid stays high until consumed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;
    logic   odd_q;
    logic   last_q;
    logic   accept;
    logic   deliver;

    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    assign in_ready   = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign load_input = in_valid & in_ready;
    assign accept     = load_input;
    assign deliver    = out_valid & out_ready;
    assign state_dbg  = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = EVEN;
            EVEN: state_nx = odd_q ? ODD : DONE;
            ODD:  state_nx = DONE;
            DONE: if (out_ready) state_nx = accept ? EVEN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane control outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            odd_q     <= 1'b0;
            last_q    <= 1'b0;
            iter_sel  <= 1'b0;
            we_result <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            pair_cnt  <= '0;
            tile_done <= 1'b0;
        end else begin
            state     <= state_nx;
            if (accept) begin
                odd_q  <= cfg_odd_en;
                last_q <= in_last;
            end
            iter_sel  <= (state_nx == ODD);
            we_result <= (state_nx == EVEN) | (state_nx == ODD);
            out_valid <= (state_nx == DONE);
            out_last  <= (state_nx == DONE) & last_q;
            busy      <= (state_nx != IDLE);
            tile_done <= 1'b0;
            if (deliver) begin
                if (out_last) begin
                    pair_cnt  <= '0;
                    tile_done <= 1'b1;
                end else begin
                    pair_cnt <= pair_cnt + 1'b1;
                end
            end
        end
    end

endmodule
